// File: rtl/ram_avalon_arb.sv
`default_nettype none
// ============================================================================
// Module      : ram_avalon_arb
// Description : Two-master Avalon-MM arbiter/sequencer for a single-port,
//               byte-banked word RAM. Turns the RAM's combinational read into
//               a registered pipelined read with fixed latency 1.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_avalon_arb #(
  parameter int a_width    = 7,
  parameter bit fixed_prio = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  // master 0
  input  logic [a_width+1:0]   m0_address,
  input  logic                 m0_read,
  input  logic                 m0_write,
  input  logic [31:0]          m0_writedata,
  input  logic [3:0]           m0_byteenable,
  output logic                 m0_waitrequest,
  output logic [31:0]          m0_readdata,
  output logic                 m0_readdatavalid,
  // master 1
  input  logic [a_width+1:0]   m1_address,
  input  logic                 m1_read,
  input  logic                 m1_write,
  input  logic [31:0]          m1_writedata,
  input  logic [3:0]           m1_byteenable,
  output logic                 m1_waitrequest,
  output logic [31:0]          m1_readdata,
  output logic                 m1_readdatavalid,
  // RAM side
  output logic [a_width-1:0]   ram_addr,
  output logic [3:0]           ram_we,
  output logic [31:0]          ram_wd,
  input  logic [31:0]          ram_rd
);

  logic        w_req0;
  logic        w_req1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_rd0;
  logic        w_rd1;
  logic        w_unused;

  logic        r_last_grant;
  logic [31:0] r_m0_readdata;
  logic [31:0] r_m1_readdata;
  logic        r_m0_readdatavalid;
  logic        r_m1_readdatavalid;

  // Byte-offset bits are meaningless for a word RAM.
  assign w_unused = ^{m0_address[1:0], m1_address[1:0]};

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // Read + write together is treated as a write, so no read data follows.
  assign w_rd0 = w_gnt0 & m0_read & ~m0_write;
  assign w_rd1 = w_gnt1 & m1_read & ~m1_write;

  // Same-cycle grant: lone requester wins; on contention fixed priority or
  // the master that was not granted last.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (w_req0 && w_req1) begin
        if (fixed_prio || r_last_grant) begin
          w_gnt0 = 1'b1;
        end else begin
          w_gnt1 = 1'b1;
        end
      end else begin
        w_gnt0 = w_req0;
        w_gnt1 = w_req1;
      end
    end
  end

  assign m0_waitrequest = w_req0 & ~w_gnt0;
  assign m1_waitrequest = w_req1 & ~w_gnt1;

  // RAM is driven by the granted master; m0's address is presented when idle.
  assign ram_addr = w_gnt1 ? m1_address[a_width+1:2] : m0_address[a_width+1:2];
  assign ram_wd   = w_gnt1 ? m1_writedata : m0_writedata;
  assign ram_we   = (w_gnt0 && m0_write) ? m0_byteenable :
                    (w_gnt1 && m1_write) ? m1_byteenable : 4'b0000;

  // Remember the last granted master; reset to 1 so m0 wins first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_gnt0) begin
      r_last_grant <= 1'b0;
    end else if (w_gnt1) begin
      r_last_grant <= 1'b1;
    end
  end

  // Master 0 read pipeline: capture RAM data on a granted read, pulse valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m0_readdata      <= 32'h0;
      r_m0_readdatavalid <= 1'b0;
    end else begin
      r_m0_readdatavalid <= w_rd0;
      if (w_rd0) begin
        r_m0_readdata <= ram_rd;
      end
    end
  end

  // Master 1 read pipeline: capture RAM data on a granted read, pulse valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m1_readdata      <= 32'h0;
      r_m1_readdatavalid <= 1'b0;
    end else begin
      r_m1_readdatavalid <= w_rd1;
      if (w_rd1) begin
        r_m1_readdata <= ram_rd;
      end
    end
  end

  assign m0_readdata      = r_m0_readdata;
  assign m0_readdatavalid = r_m0_readdatavalid;
  assign m1_readdata      = r_m1_readdata;
  assign m1_readdatavalid = r_m1_readdatavalid;

endmodule
`default_nettype wire
